cpu_core: RTL and testbench

- Multicycle, non-pipelined 32-bit processor core executing a subset of the team's 5-bit-opcode RISC ISA.
- Sits between the synchronous instruction ROM, the external 32x32 register file and the synchronous data RAM in the top-level wrapper.
- Holds only PC, instruction register and operand/result latches. Architectural registers live in the external regfile.

---
 rtl/cpu_core.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_cpu_core.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: multicycle, non-pipelined 32-bit core (FETCH -> DECODE -> EXEC -> WB)
// for the 5-bit-opcode RISC subset. Holds PC, IR and operand/result latches only;
// architectural registers live in the external regfile.
// Optional feature macro: OVF_STATUS_EN. When defined, a signed overflow on
// add/addi/sub redirects the WB write to r30 with a status code (1/2/3).
module cpu_core #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RW     = 5;
    localparam int unsigned IMM_W  = 17;
    localparam int unsigned TGT_W  = 27;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;

    localparam logic [RW-1:0] REG_LINK = 5'd31;
`ifdef OVF_STATUS_EN
    localparam logic [RW-1:0] REG_OVF  = 5'd30;
`endif

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_e;

    // Architectural / sequencing state
    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   ir_q;
    logic [XLEN-1:0]   opa_q;
    logic [XLEN-1:0]   opb_q;

    // Registered memory-side outputs (live during EXEC)
    logic              wren_q;
    logic [XLEN-1:0]   dmem_addr_q;
    logic [XLEN-1:0]   dmem_data_q;

    // Registered regfile-side outputs (live during WB)
    logic              wen_q;
    logic [RW-1:0]     wreg_q;
    logic [XLEN-1:0]   wdata_q;
    logic              wmem_q;

    // Next values produced by the decode and execute datapaths
    logic              wren_d;
    logic [XLEN-1:0]   dmem_addr_d;
    logic [XLEN-1:0]   pc_d;
    logic              wen_d;
    logic [RW-1:0]     wreg_d;
    logic [XLEN-1:0]   wdata_d;
    logic              wmem_d;

    // Register-index source: the incoming ROM word while decoding, IR otherwise
    logic [4:0]        sel_op;
    logic [RW-1:0]     sel_rd;
    logic [RW-1:0]     sel_rs;
    logic [RW-1:0]     sel_rt;

    // Execute-stage fields and arithmetic
    logic [4:0]        ex_op;
    logic [RW-1:0]     ex_rd;
    logic [4:0]        ex_shamt;
    logic [4:0]        ex_alu;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_target;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   br_target;
    logic [XLEN-1:0]   sum_ab;
    logic [XLEN-1:0]   diff_ab;
    logic [XLEN-1:0]   sum_ai;
    logic [XLEN-1:0]   dec_imm;
    logic              unused_ir;

    assign ex_op     = ir_q[31:27];
    assign ex_rd     = ir_q[26:22];
    assign ex_shamt  = ir_q[11:7];
    assign ex_alu    = ir_q[6:2];
    assign ex_imm    = {{(XLEN-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
    assign ex_target = {{(XLEN-TGT_W){1'b0}}, ir_q[TGT_W-1:0]};
    assign pc_inc    = pc_q + XLEN'(1);
    assign br_target = pc_inc + ex_imm;
    assign sum_ab    = opa_q + opb_q;
    assign diff_ab   = opa_q - opb_q;
    assign sum_ai    = opa_q + ex_imm;
    assign dec_imm   = {{(XLEN-IMM_W){q_imem[IMM_W-1]}}, q_imem[IMM_W-1:0]};
    assign unused_ir = ^ir_q[1:0];

`ifdef OVF_STATUS_EN
    logic ovf_add;
    logic ovf_sub;
    logic ovf_addi;

    assign ovf_add  = (opa_q[XLEN-1] == opb_q[XLEN-1])  && (sum_ab[XLEN-1]  != opa_q[XLEN-1]);
    assign ovf_sub  = (opa_q[XLEN-1] != opb_q[XLEN-1])  && (diff_ab[XLEN-1] != opa_q[XLEN-1]);
    assign ovf_addi = (opa_q[XLEN-1] == ex_imm[XLEN-1]) && (sum_ai[XLEN-1]  != opa_q[XLEN-1]);
`endif

    // Regfile read indices: B port carries rd for instructions that compare or store rd
    always_comb begin
        if (state_q == S_DECODE) begin
            sel_op = q_imem[31:27];
            sel_rd = q_imem[26:22];
            sel_rs = q_imem[21:17];
            sel_rt = q_imem[16:12];
        end else begin
            sel_op = ir_q[31:27];
            sel_rd = ir_q[26:22];
            sel_rs = ir_q[21:17];
            sel_rt = ir_q[16:12];
        end
        ctrl_readRegA = sel_rs;
        case (sel_op)
            OP_SW, OP_BNE, OP_BLT, OP_JR: ctrl_readRegB = sel_rd;
            default:                      ctrl_readRegB = sel_rt;
        endcase
    end

    // Memory request computed while decoding so it is registered for EXEC
    always_comb begin
        wren_d      = (q_imem[31:27] == OP_SW);
        dmem_addr_d = data_readRegA + dec_imm;
    end

    // Execute: ALU result, writeback selection and next PC
    always_comb begin
        pc_d    = pc_inc;
        wen_d   = 1'b0;
        wreg_d  = ex_rd;
        wdata_d = '0;
        wmem_d  = 1'b0;
        case (ex_op)
            OP_RTYPE: begin
                case (ex_alu)
                    ALU_ADD: begin
                        wen_d   = 1'b1;
                        wdata_d = sum_ab;
`ifdef OVF_STATUS_EN
                        if (ovf_add) begin
                            wreg_d  = REG_OVF;
                            wdata_d = XLEN'(1);
                        end
`endif
                    end
                    ALU_SUB: begin
                        wen_d   = 1'b1;
                        wdata_d = diff_ab;
`ifdef OVF_STATUS_EN
                        if (ovf_sub) begin
                            wreg_d  = REG_OVF;
                            wdata_d = XLEN'(3);
                        end
`endif
                    end
                    ALU_AND: begin
                        wen_d   = 1'b1;
                        wdata_d = opa_q & opb_q;
                    end
                    ALU_OR: begin
                        wen_d   = 1'b1;
                        wdata_d = opa_q | opb_q;
                    end
                    ALU_SLL: begin
                        wen_d   = 1'b1;
                        wdata_d = opa_q << ex_shamt;
                    end
                    ALU_SRA: begin
                        wen_d   = 1'b1;
                        wdata_d = $signed(opa_q) >>> ex_shamt;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                wen_d   = 1'b1;
                wdata_d = sum_ai;
`ifdef OVF_STATUS_EN
                if (ovf_addi) begin
                    wreg_d  = REG_OVF;
                    wdata_d = XLEN'(2);
                end
`endif
            end
            OP_LW: begin
                wen_d  = 1'b1;
                wmem_d = 1'b1;
            end
            OP_J: pc_d = ex_target;
            OP_BNE: begin
                if (opb_q != opa_q) pc_d = br_target;
            end
            OP_JAL: begin
                wen_d   = 1'b1;
                wreg_d  = REG_LINK;
                wdata_d = pc_inc;
                pc_d    = ex_target;
            end
            OP_JR: pc_d = opb_q;
            OP_BLT: begin
                if ($signed(opb_q) < $signed(opa_q)) pc_d = br_target;
            end
            default: ;
        endcase
        // r0 is never written
        if (wreg_d == '0) wen_d = 1'b0;
    end

    // Sequencer: four states per instruction with registered strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            wren_q      <= 1'b0;
            dmem_addr_q <= '0;
            dmem_data_q <= '0;
            wen_q       <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            wmem_q      <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_q        <= q_imem;
                    opa_q       <= data_readRegA;
                    opb_q       <= data_readRegB;
                    wren_q      <= wren_d;
                    dmem_addr_q <= dmem_addr_d;
                    dmem_data_q <= data_readRegB;
                    state_q     <= S_EXEC;
                end
                S_EXEC: begin
                    pc_q    <= pc_d;
                    wren_q  <= 1'b0;
                    wen_q   <= wen_d;
                    wreg_q  <= wreg_d;
                    wdata_q <= wdata_d;
                    wmem_q  <= wmem_d;
                    state_q <= S_WB;
                end
                S_WB: begin
                    wen_q   <= 1'b0;
                    wmem_q  <= 1'b0;
                    state_q <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign address_imem     = pc_q;
    assign wren             = wren_q;
    assign address_dmem     = dmem_addr_q;
    assign data             = dmem_data_q;
    assign ctrl_writeEnable = wen_q;
    assign ctrl_writeReg    = wreg_q;
    // Load data arrives from the RAM during WB, so it bypasses the result latch
    assign data_writeReg    = wmem_q ? q_dmem : wdata_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: ROM/regfile/RAM environment around cpu_core, directed programs
// plus random programs checked against an instruction-level ISA model.
module tb_cpu_core;

`ifdef OVF_STATUS_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;

    logic [31:0] rom [64];
    logic [31:0] ram [64];
    logic [31:0] rf  [32];
    logic        clr = 1'b0;

    // Reference model state
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_pc;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_core #(.RESET_PC(32'd0)) dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wren             (wren),
        .address_dmem     (address_dmem),
        .data             (data),
        .q_dmem           (q_dmem)
    );

    always #5 clock = ~clock;

    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    // Synchronous ROM, RAM and regfile write port
    always @(posedge clock) begin
        q_imem <= rom[address_imem[5:0]];
        q_dmem <= ram[address_dmem[5:0]];
        if (clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else begin
            if (wren) ram[address_dmem[5:0]] <= data;
            if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt,
                                          input int sh, input int alu);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(alu), 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int tgt);
        return {5'(op), 27'(tgt)};
    endfunction

    function automatic int rreg();
        int r = int'($urandom_range(0, 9));
        if (r == 8) return 30;
        if (r == 9) return 31;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        int sel = int'($urandom_range(0, 13));
        int simm = int'($urandom_range(0, 16)) - 8;
        case (sel)
            0, 1, 2: return enc_r(rreg(), rreg(), rreg(), int'($urandom_range(0, 31)),
                                  int'($urandom_range(0, 7)));
            3, 4:    return enc_i(5, rreg(), rreg(), simm);
            5:       return enc_i(7, rreg(), rreg(), int'($urandom_range(0, 63)));
            6:       return enc_i(8, rreg(), rreg(), int'($urandom_range(0, 63)));
            7:       return enc_j(1, int'($urandom_range(0, 63)));
            8:       return enc_i(2, rreg(), rreg(), simm);
            9:       return enc_j(3, int'($urandom_range(0, 63)));
            10:      return enc_i(4, rreg(), 0, 0);
            11:      return enc_i(6, rreg(), rreg(), simm);
            12:      return {5'($urandom_range(9, 31)), 27'($urandom)};
            default: return enc_i(5, rreg(), rreg(), int'($urandom_range(0, 131071)));
        endcase
    endfunction

    // ISA-level model: executes one instruction and reports the expected side effects
    task automatic model_step(output logic we, output logic [4:0] wr, output logic [31:0] wd,
                              output logic mw, output logic [31:0] ma, output logic [31:0] md);
        logic [31:0] ins, a, b, t, imm, nxt, code;
        logic [4:0]  op, rd, rs, rt, sh, alu;
        longint      full;
        bit          ovf;
        ins  = rom[m_pc[5:0]];
        op   = ins[31:27]; rd = ins[26:22]; rs = ins[21:17];
        rt   = ins[16:12]; sh = ins[11:7];  alu = ins[6:2];
        imm  = 32'($signed(ins[16:0]));
        a    = m_reg[rs]; b = m_reg[rd]; t = m_reg[rt];
        we   = 1'b0; wr = rd; wd = '0; mw = 1'b0;
        ma   = a + imm; md = b; ovf = 1'b0; code = '0;
        nxt  = m_pc + 1;
        case (op)
            5'd0: case (alu)
                5'd0: begin
                    wd = a + t; we = 1'b1; code = 1;
                    full = longint'($signed(a)) + longint'($signed(t));
                    ovf = (full != longint'($signed(wd)));
                end
                5'd1: begin
                    wd = a - t; we = 1'b1; code = 3;
                    full = longint'($signed(a)) - longint'($signed(t));
                    ovf = (full != longint'($signed(wd)));
                end
                5'd2: begin wd = a & t; we = 1'b1; end
                5'd3: begin wd = a | t; we = 1'b1; end
                5'd4: begin wd = a << sh; we = 1'b1; end
                5'd5: begin wd = $signed(a) >>> sh; we = 1'b1; end
                default: ;
            endcase
            5'd5: begin
                wd = a + imm; we = 1'b1; code = 2;
                full = longint'($signed(a)) + longint'($signed(imm));
                ovf = (full != longint'($signed(wd)));
            end
            5'd7: begin mw = 1'b1; m_mem[ma[5:0]] = b; end
            5'd8: begin we = 1'b1; wd = m_mem[ma[5:0]]; end
            5'd1: nxt = {5'd0, ins[26:0]};
            5'd2: if (b != a) nxt = m_pc + 1 + imm;
            5'd3: begin we = 1'b1; wr = 5'd31; wd = m_pc + 1; nxt = {5'd0, ins[26:0]}; end
            5'd4: nxt = b;
            5'd6: if ($signed(b) < $signed(a)) nxt = m_pc + 1 + imm;
            default: ;
        endcase
        if (OVF_EN && ovf) begin wr = 5'd30; wd = code; end
        if (wr == 5'd0) we = 1'b0;
        if (we) m_reg[wr] = wd;
        m_pc = nxt;
    endtask

    // Reset DUT and environment; returns at a falling edge in the first FETCH cycle
    task automatic do_reset();
        reset = 1'b0;
        clr   = 1'b1;
        @(negedge clock);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_we", 32'(ctrl_writeEnable), 32'd0);
        check("rst_pc", address_imem, 32'd0);
        @(negedge clock);
        clr = 1'b0;
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Run n instructions, checking each state's outputs against the model
    task automatic run_prog(input int n);
        logic we, mw;
        logic [4:0] wr;
        logic [31:0] wd, ma, md;
        for (int i = 0; i < n; i++) begin
            check("fetch_pc", address_imem, m_pc);
            check("fetch_we", 32'(ctrl_writeEnable), 32'd0);
            model_step(we, wr, wd, mw, ma, md);
            @(negedge clock);
            check("decode_wren", 32'(wren), 32'd0);
            @(negedge clock);
            check("exec_wren", 32'(wren), 32'(mw));
            if (mw) begin
                check("exec_addr", address_dmem, ma);
                check("exec_data", data, md);
            end
            @(negedge clock);
            check("wb_wren", 32'(wren), 32'd0);
            check("wb_we", 32'(ctrl_writeEnable), 32'(we));
            if (we) begin
                check("wb_reg", 32'(ctrl_writeReg), 32'(wr));
                check("wb_data", data_writeReg, wd);
            end
            @(negedge clock);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'hF800_0000;
    endtask

    initial begin
        // addi/add sequence
        clear_rom();
        rom[0] = enc_i(5, 1, 0, 5);
        rom[1] = enc_i(5, 2, 0, -3);
        rom[2] = enc_r(3, 1, 2, 0, 0);
        do_reset();
        run_prog(3);
        check("p1_pc", address_imem, 32'd3);
        check("p1_r1", rf[1], 32'd5);
        check("p1_r2", rf[2], 32'hFFFF_FFFD);
        check("p1_r3", rf[3], 32'd2);

        // shifts and sub
        clear_rom();
        rom[0] = enc_i(5, 1, 0, 65535);
        rom[1] = enc_r(2, 1, 0, 16, 4);
        rom[2] = enc_r(3, 2, 0, 4, 5);
        rom[3] = enc_r(4, 0, 1, 0, 1);
        do_reset();
        run_prog(4);
        check("p2_r2", rf[2], 32'hFFFF_0000);
        check("p2_r3", rf[3], 32'hFFFF_F000);
        check("p2_r4", rf[4], 32'hFFFF_0001);

        // store then load
        clear_rom();
        rom[0] = enc_i(5, 1, 0, 7);
        rom[1] = enc_i(7, 1, 0, 12);
        rom[2] = enc_i(8, 5, 0, 12);
        do_reset();
        run_prog(3);
        check("p3_ram12", ram[12], 32'd7);
        check("p3_r5", rf[5], 32'd7);

        // bne taken over two addi, blt taken on -1 < 0
        clear_rom();
        rom[0] = enc_i(5, 1, 0, 1);
        rom[1] = enc_i(2, 1, 0, 2);
        rom[2] = enc_i(5, 7, 0, 1);
        rom[3] = enc_i(5, 8, 0, 1);
        rom[4] = enc_i(5, 6, 0, 9);
        rom[5] = enc_i(5, 9, 0, -1);
        rom[6] = enc_i(6, 9, 0, 1);
        rom[7] = enc_i(5, 10, 0, 1);
        rom[8] = enc_i(5, 11, 0, 2);
        do_reset();
        run_prog(6);
        check("p4_pc", address_imem, 32'd9);
        check("p4_r6", rf[6], 32'd9);
        check("p4_r7", rf[7], 32'd0);
        check("p4_r8", rf[8], 32'd0);
        check("p4_r10", rf[10], 32'd0);
        check("p4_r11", rf[11], 32'd2);

        // jal from PC 4, jr back through r31
        clear_rom();
        rom[4]  = enc_j(3, 10);
        rom[10] = enc_i(4, 31, 0, 0);
        do_reset();
        run_prog(5);
        check("p5_jal_pc", address_imem, 32'd10);
        check("p5_r31", rf[31], 32'd5);
        run_prog(1);
        check("p5_jr_pc", address_imem, 32'd5);

        // reset asserted during EXEC of sw aborts the store
        clear_rom();
        rom[0] = enc_i(5, 1, 0, 7);
        rom[1] = enc_i(7, 1, 0, 12);
        do_reset();
        repeat (6) @(posedge clock);
        #2;
        check("p6_wren_exec", 32'(wren), 32'd1);
        reset = 1'b0;
        #1;
        check("p6_wren_rst", 32'(wren), 32'd0);
        check("p6_pc_rst", address_imem, 32'd0);
        @(negedge clock);
        @(negedge clock);
        check("p6_ram12", ram[12], 32'd0);
        check("p6_r1", rf[1], 32'd7);

`ifdef OVF_STATUS_EN
        // 0x7FFFFFFF + 1 overflows into the status register
        clear_rom();
        rom[0] = enc_i(5, 1, 0, 32767);
        rom[1] = enc_r(1, 1, 0, 16, 4);
        rom[2] = enc_i(5, 2, 0, 65535);
        rom[3] = enc_r(1, 1, 2, 0, 3);
        rom[4] = enc_i(5, 3, 0, 1);
        rom[5] = enc_r(4, 1, 3, 0, 0);
        do_reset();
        run_prog(6);
        check("ovf_r1", rf[1], 32'h7FFF_FFFF);
        check("ovf_r30", rf[30], 32'd1);
        check("ovf_r4", rf[4], 32'd0);
`endif

        // random programs against the model
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 64; k++) rom[k] = rand_instr();
            do_reset();
            run_prog(60);
            for (int r = 0; r < 32; r++) check("rand_rf", rf[r], m_reg[r]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
